// File: rtl/pipe_pkg.sv
// Shared definitions for the ID-stage hazard, forwarding and scoreboard logic.
package pipe_pkg;

   localparam int NREG_DEF = 32;
   localparam int RW_DEF   = 5;

   // Operand source select seen by the EX-stage operand muxes.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EXE = 2'b01,
      FWD_MEM = 2'b10,
      FWD_MLD = 2'b11
   } fwd_sel_e;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding select. With forwarding disabled the select stays at
// the register file and any EX/MEM producer match is reported as a stall term.
module pipe_fwd_sel
   import pipe_pkg::*;
#(
   parameter int RW     = RW_DEF,
   parameter bit FWD_EN = 1'b1
) (
   input  logic [RW-1:0] src,
   input  logic          use_src,
   input  logic          ewreg,
   input  logic          em2reg,
   input  logic [RW-1:0] ern,
   input  logic          mwreg,
   input  logic          mm2reg,
   input  logic [RW-1:0] mrn,
   output logic [1:0]    sel,
   output logic          nofwd
);

   logic ex_hit;
   logic mem_hit;

   // Register 0 is hard-wired, so a producer targeting it never matches.
   assign ex_hit  = ewreg && (ern != '0) && (ern == src);
   assign mem_hit = mwreg && (mrn != '0) && (mrn == src);

   // Select the youngest producer; EX beats MEM.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      sel   = FWD_RF;
      nofwd = 1'b0;
      if (FWD_EN) begin
         if (ex_hit && !em2reg)
            sel = FWD_EXE;
         else if (mem_hit && !mm2reg)
            sel = FWD_MEM;
         else if (mem_hit)
            sel = FWD_MLD;
      end else begin
         nofwd = use_src && (ex_hit || mem_hit);
      end
   end

endmodule

// File: rtl/pipe_hazard_sb.sv
// ID-stage hazard unit: load-use and no-forward stalls, a one-entry MDU
// scoreboard (RAW, WAW and structural stalls), forwarding selects and
// stall/error statistics.
module pipe_hazard_sb
   import pipe_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int RW     = RW_DEF,
   parameter bit FWD_EN = 1'b1,
   parameter int CW     = 16
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            id_valid,
   input  logic [RW-1:0]   id_rs,
   input  logic [RW-1:0]   id_rt,
   input  logic            id_use_rs,
   input  logic            id_use_rt,
   input  logic            id_wreg,
   input  logic [RW-1:0]   id_rn,
   input  logic            id_long,
   input  logic            ewreg,
   input  logic            em2reg,
   input  logic [RW-1:0]   ern,
   input  logic            mwreg,
   input  logic            mm2reg,
   input  logic [RW-1:0]   mrn,
   input  logic            mdu_done,
   input  logic [RW-1:0]   mdu_rn,
   input  logic            stat_clr,
   output logic [1:0]      fwda,
   output logic [1:0]      fwdb,
   output logic            nostall,
   output logic            issue,
   output logic [NREG-1:0] sb_pend,
   output logic            mdu_busy,
   output logic [CW-1:0]   stall_cnt,
   output logic            err_spurious
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   logic nofwd_a;
   logic nofwd_b;
   logic ld_hz;
   logic raw_hz;
   logic waw_hz;
   logic str_hz;
   logic stall;

   pipe_fwd_sel #(.RW(RW), .FWD_EN(FWD_EN)) u_fwd_a (
      .src(id_rs), .use_src(id_use_rs),
      .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
      .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
      .sel(fwda), .nofwd(nofwd_a)
   );

   pipe_fwd_sel #(.RW(RW), .FWD_EN(FWD_EN)) u_fwd_b (
      .src(id_rt), .use_src(id_use_rt),
      .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
      .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
      .sel(fwdb), .nofwd(nofwd_b)
   );

   // Collect the stall terms; nothing stalls without a valid instruction in ID.
   always_comb begin
      ld_hz  = ewreg && em2reg && (ern != '0) &&
               ((id_use_rs && (ern == id_rs)) || (id_use_rt && (ern == id_rt)));
      // The MDU result is not bypassed, so a pending source stalls even on done.
      raw_hz = (id_use_rs && sb_pend[id_rs]) || (id_use_rt && sb_pend[id_rt]);
      waw_hz = id_wreg && sb_pend[id_rn];
      // A new MDU op may enter in the same cycle the previous one completes.
      str_hz = id_long && mdu_busy && !mdu_done;
      stall  = id_valid && (ld_hz || nofwd_a || nofwd_b || raw_hz || waw_hz || str_hz);
   end

   assign nostall = !stall;
   assign issue   = id_valid && !stall;

   // Scoreboard: completion clears, issue of an MDU op sets; the set is
   // written last so it wins when both hit the same cycle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         // NOTE: the pending vector is a handful of flops, not a RAM, so it
         // takes the asynchronous reset like any other control state.
         sb_pend  <= '0;
         mdu_busy <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here; the later assignment to the same
         // bit takes effect, which gives set-over-clear without extra logic.
         if (mdu_done) begin
            sb_pend[mdu_rn] <= 1'b0;
            mdu_busy        <= 1'b0;
         end
         if (issue && id_long) begin
            mdu_busy <= 1'b1;
            if (id_rn != '0)
               sb_pend[id_rn] <= 1'b1;
         end
      end
   end

   // Sticky flag for an MDU completion that matches nothing outstanding.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         err_spurious <= 1'b0;
      else if (stat_clr)
         err_spurious <= 1'b0;
      else if (mdu_done && (!sb_pend[mdu_rn] || !mdu_busy))
         err_spurious <= 1'b1;
   end

   // Saturating count of cycles where a valid instruction was held in ID.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         stall_cnt <= '0;
      else if (stat_clr)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != CNT_MAX))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_pipe_hazard_sb.sv
// Bench for pipe_hazard_sb: a default instance plus a no-forwarding instance
// and a 2-bit-counter instance, all driven with the same stimulus.
module tb_pipe_hazard_sb;

   localparam int NREG = 32;
   localparam int RW   = 5;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] obs_q[$];
   int          checks   = 0;
   int          failures = 0;

   logic            clock = 1'b0;
   logic            resetn;
   logic            id_valid, id_use_rs, id_use_rt, id_wreg, id_long;
   logic [RW-1:0]   id_rs, id_rt, id_rn, ern, mrn, mdu_rn;
   logic            ewreg, em2reg, mwreg, mm2reg, mdu_done, stat_clr;

   logic [1:0]      dut_fwda, dut_fwdb, nf_fwda, nf_fwdb, sat_fwda, sat_fwdb;
   logic            dut_nostall, dut_issue, dut_busy, dut_err;
   logic            nf_nostall, nf_issue, nf_busy, nf_err;
   logic            sat_nostall, sat_issue, sat_busy, sat_err;
   logic [NREG-1:0] dut_pend, nf_pend, sat_pend;
   logic [15:0]     dut_cnt, nf_cnt;
   logic [1:0]      sat_cnt;

   always #5 clock = ~clock;

   pipe_hazard_sb #(.NREG(NREG), .RW(RW), .FWD_EN(1'b1), .CW(16)) u_dut (
      .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_rn(id_rn),
      .id_long(id_long), .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg),
      .mm2reg(mm2reg), .mrn(mrn), .mdu_done(mdu_done), .mdu_rn(mdu_rn), .stat_clr(stat_clr),
      .fwda(dut_fwda), .fwdb(dut_fwdb), .nostall(dut_nostall), .issue(dut_issue),
      .sb_pend(dut_pend), .mdu_busy(dut_busy), .stall_cnt(dut_cnt), .err_spurious(dut_err)
   );

   pipe_hazard_sb #(.NREG(NREG), .RW(RW), .FWD_EN(1'b0), .CW(16)) u_nofwd (
      .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_rn(id_rn),
      .id_long(id_long), .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg),
      .mm2reg(mm2reg), .mrn(mrn), .mdu_done(mdu_done), .mdu_rn(mdu_rn), .stat_clr(stat_clr),
      .fwda(nf_fwda), .fwdb(nf_fwdb), .nostall(nf_nostall), .issue(nf_issue),
      .sb_pend(nf_pend), .mdu_busy(nf_busy), .stall_cnt(nf_cnt), .err_spurious(nf_err)
   );

   pipe_hazard_sb #(.NREG(NREG), .RW(RW), .FWD_EN(1'b1), .CW(2)) u_sat (
      .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_rn(id_rn),
      .id_long(id_long), .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg),
      .mm2reg(mm2reg), .mrn(mrn), .mdu_done(mdu_done), .mdu_rn(mdu_rn), .stat_clr(stat_clr),
      .fwda(sat_fwda), .fwdb(sat_fwdb), .nostall(sat_nostall), .issue(sat_issue),
      .sb_pend(sat_pend), .mdu_busy(sat_busy), .stall_cnt(sat_cnt), .err_spurious(sat_err)
   );

   // Expected value enters the scoreboard when the stimulus is driven.
   task automatic want(input string n, input logic [31:0] v);
      exp_q.push_back('{name: n, val: v});
   endtask

   // Observed value recorded at the sample point, in the same order as want().
   task automatic got(input logic [31:0] v);
      obs_q.push_back(v);
   endtask

   task automatic idle();
      id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_wreg = 0; id_long = 0;
      id_rs = 0; id_rt = 0; id_rn = 0;
      ewreg = 0; em2reg = 0; ern = 0; mwreg = 0; mm2reg = 0; mrn = 0;
      mdu_done = 0; mdu_rn = 0; stat_clr = 0;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_clr();
      stat_clr = 1;
      tick();
      stat_clr = 0;
   endtask

   task automatic test_reset();
      exp_t e;
      logic [31:0] o;
      idle();
      resetn = 1;
      #1 resetn = 0;
      want("rst pend", 0); want("rst busy", 0); want("rst cnt", 0);
      want("rst err", 0); want("rst nostall", 1); want("rst issue", 0);
      #2;
      got(32'(dut_pend)); got(32'(dut_busy)); got(32'(dut_cnt));
      got(32'(dut_err)); got(32'(dut_nostall)); got(32'(dut_issue));
      #5 resetn = 1;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_load_use();
      exp_t e;
      logic [31:0] o;
      tick();
      id_valid = 1; id_rs = 5; id_use_rs = 1; ewreg = 1; em2reg = 1; ern = 5;
      want("lu nostall", 0); want("lu issue", 0); want("lu cnt0", 0); want("lu nf nostall", 0);
      #2;
      got(32'(dut_nostall)); got(32'(dut_issue)); got(32'(dut_cnt)); got(32'(nf_nostall));
      tick();
      ewreg = 0; em2reg = 0; ern = 0; mwreg = 1; mm2reg = 1; mrn = 5;
      want("lu2 nostall", 1); want("lu2 fwda", 3); want("lu2 fwdb", 0); want("lu2 cnt1", 1);
      want("lu2 nf fwda", 0); want("lu2 nf nostall", 0);
      #2;
      got(32'(dut_nostall)); got(32'(dut_fwda)); got(32'(dut_fwdb)); got(32'(dut_cnt));
      got(32'(nf_fwda)); got(32'(nf_nostall));
      idle();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_priority();
      exp_t e;
      logic [31:0] o;
      tick();
      id_valid = 1; id_rt = 7; id_use_rt = 1;
      ewreg = 1; mwreg = 1; em2reg = 0; mm2reg = 0; ern = 7; mrn = 7;
      want("pri fwdb ex", 1); want("pri nostall", 1); want("pri nf fwdb", 0); want("pri nf nostall", 0);
      #2;
      got(32'(dut_fwdb)); got(32'(dut_nostall)); got(32'(nf_fwdb)); got(32'(nf_nostall));
      ewreg = 0;
      want("pri fwdb mem", 2); want("pri nf fwdb2", 0); want("pri nf nostall2", 0);
      #2;
      got(32'(dut_fwdb)); got(32'(nf_fwdb)); got(32'(nf_nostall));
      // Register 0 never forwards and never causes a load-use stall.
      idle();
      id_valid = 1; id_rs = 0; id_use_rs = 1; ewreg = 1; em2reg = 1; ern = 0;
      want("r0 fwda", 0); want("r0 nostall", 1); want("r0 nf nostall", 1);
      #2;
      got(32'(dut_fwda)); got(32'(dut_nostall)); got(32'(nf_nostall));
      idle();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_sb_raw();
      exp_t e;
      logic [31:0] o;
      pulse_clr();
      id_valid = 1; id_long = 1; id_wreg = 1; id_rn = 9;
      want("raw issue long", 1);
      #2;
      got(32'(dut_issue));
      tick();
      idle();
      id_valid = 1; id_rs = 9; id_use_rs = 1;
      want("raw pend", 32'h200); want("raw busy", 1); want("raw stall1", 0);
      #2;
      got(32'(dut_pend)); got(32'(dut_busy)); got(32'(dut_nostall));
      tick();
      want("raw stall2", 0);
      #2;
      got(32'(dut_nostall));
      tick();
      mdu_done = 1; mdu_rn = 9;
      want("raw no bypass", 0);
      #2;
      got(32'(dut_nostall));
      tick();
      mdu_done = 0; mdu_rn = 0;
      want("raw issue", 1); want("raw pend clr", 0); want("raw busy clr", 0);
      want("raw err", 0); want("raw cnt", 3);
      #2;
      got(32'(dut_issue)); got(32'(dut_pend)); got(32'(dut_busy));
      got(32'(dut_err)); got(32'(dut_cnt));
      idle();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_struct_waw();
      exp_t e;
      logic [31:0] o;
      tick();
      id_valid = 1; id_long = 1; id_wreg = 1; id_rn = 9;
      tick();
      id_rn = 12;
      want("str stall", 0);
      #2;
      got(32'(dut_nostall));
      mdu_done = 1; mdu_rn = 9;
      want("str done nostall", 1); want("str done issue", 1);
      #2;
      got(32'(dut_nostall)); got(32'(dut_issue));
      tick();
      idle();
      id_valid = 1; id_wreg = 1; id_rn = 12;
      want("b2b busy", 1); want("b2b pend", 32'h1000); want("b2b err", 0); want("waw stall", 0);
      #2;
      got(32'(dut_busy)); got(32'(dut_pend)); got(32'(dut_err)); got(32'(dut_nostall));
      idle();
      mdu_done = 1; mdu_rn = 12;
      tick();
      idle();
      want("str drain busy", 0); want("str drain pend", 0); want("str drain err", 0);
      #2;
      got(32'(dut_busy)); got(32'(dut_pend)); got(32'(dut_err));
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      logic [31:0] o;
      pulse_clr();
      id_valid = 1; id_long = 1; id_wreg = 1; id_rn = 9;
      tick();
      idle();
      id_valid = 1; id_rs = 9; id_use_rs = 1;
      for (int i = 0; i < 3; i++) tick();
      want("rm pend", 32'h200); want("rm cnt", 3); want("rm stall", 0);
      #2;
      got(32'(dut_pend)); got(32'(dut_cnt)); got(32'(dut_nostall));
      resetn = 0;
      want("rm rst pend", 0); want("rm rst busy", 0); want("rm rst cnt", 0);
      want("rm rst err", 0); want("rm rst nostall", 1);
      #1;
      got(32'(dut_pend)); got(32'(dut_busy)); got(32'(dut_cnt));
      got(32'(dut_err)); got(32'(dut_nostall));
      #1 resetn = 1;
      tick();
      want("rm issue", 1); want("rm cnt after", 0);
      #2;
      got(32'(dut_issue)); got(32'(dut_cnt));
      idle();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_err_sat();
      exp_t e;
      logic [31:0] o;
      tick();
      mdu_done = 1; mdu_rn = 4;
      tick();
      idle();
      want("err set", 1);
      #2;
      got(32'(dut_err));
      tick();
      want("err sticky", 1);
      #2;
      got(32'(dut_err));
      pulse_clr();
      want("err clr", 0); want("cnt clr", 0);
      #2;
      got(32'(dut_err)); got(32'(dut_cnt));
      id_valid = 1; id_rs = 5; id_use_rs = 1; ewreg = 1; em2reg = 1; ern = 5;
      for (int i = 0; i < 5; i++) tick();
      idle();
      want("sat cnt", 3); want("wide cnt", 5);
      #2;
      got(32'(sat_cnt)); got(32'(dut_cnt));
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", e.name, o, e.val);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_load_use();
      test_priority();
      test_sb_raw();
      test_struct_waw();
      test_reset_mid();
      test_err_sat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_sb.md
Name: pipe_hazard_sb

Overview:
- Parametrised hazard, forwarding and scoreboard unit for the 5-stage pipeline's ID stage; next generation of the combinational ID-stage hazard logic.
- Adds a register scoreboard for one outstanding variable-latency multiply/divide (MDU) operation, with RAW, WAW and structural stall detection.
- Optional forwarding disable; saturating stall-cycle counter and sticky protocol-error flag.
- Sits beside the ID control decoder. The decoder supplies operand-use and write flags; this block returns forwarding selects and `nostall`.

Parameters:
- NREG, 32, number of architectural registers (power of 2, ≥ 2).
- RW, 5, register index width, equal to log2(NREG).
- FWD_EN, 1, 1 = E/M forwarding enabled; 0 = every E/M RAW dependence stalls.
- CW, 16, width of stall counter.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in ID
- id_rs, id_rt  in  RW  source register indices
- id_use_rs, id_use_rt  in  1  instruction reads rs / rt
- id_wreg  in  1  instruction writes a register
- id_rn  in  RW  destination register
- id_long  in  1  instruction is an MDU (multi-cycle) op
- ewreg, em2reg  in  1  EX-stage write / load flags
- ern  in  RW  EX-stage destination
- mwreg, mm2reg  in  1  MEM-stage write / load flags
- mrn  in  RW  MEM-stage destination
- mdu_done  in  1  MDU result written back this cycle
- mdu_rn  in  RW  register written by MDU
- stat_clr  in  1  synchronous clear of stall_cnt and err_spurious
- fwda, fwdb  out  2  operand A / B select: 00 reg file, 01 EX ALU, 10 MEM ALU, 11 MEM load data
- nostall  out  1  0 = freeze PC/IF-ID, bubble into EX
- issue  out  1  id_valid & nostall
- sb_pend  out  NREG  scoreboard pending vector
- mdu_busy  out  1  MDU op outstanding
- stall_cnt  out  CW  saturating count of stalled cycles
- err_spurious  out  1  sticky: mdu_done on a non-pending register

Behaviour:
- Reset (resetn=0, asynchronous): sb_pend=0, mdu_busy=0, stall_cnt=0, err_spurious=0.
- Combinational outputs are valid whenever their inputs are stable.
- Register 0 never becomes pending and never forwards. Any compare involving index 0 is false.
- Stall terms, all qualified by id_valid:
  - ld: ewreg & em2reg & ern≠0 & (use_rs & ern==rs | use_rt & ern==rt).
  - nofwd (FWD_EN=0 only): an E or M stage with wreg, rn≠0, matching a used source.
  - raw: (use_rs & sb_pend[rs]) | (use_rt & sb_pend[rt]). No same-cycle bypass from mdu_done; the stall lasts one more cycle after done.
  - waw: id_wreg & sb_pend[id_rn].
  - str: id_long & mdu_busy & ~mdu_done. Issue is allowed in the same cycle as done.
- nostall = ~(ld | nofwd | raw | waw | str). When id_valid=0, nostall=1.
- Forwarding (FWD_EN=1), per operand:
  - EX match & ~em2reg → 01.
  - else MEM match & ~mm2reg → 10.
  - else MEM match & mm2reg → 11.
  - else 00.
  - EX has priority over MEM. When FWD_EN=0, fwda = fwdb = 00.
- Sequential updates on each clock edge:
  - If mdu_done: clear sb_pend[mdu_rn]. If that bit was 0, or mdu_busy=0, set err_spurious. Clear mdu_busy.
  - If issue & id_long: set mdu_busy. If id_rn≠0, set sb_pend[id_rn].
  - When a set and a clear happen in the same cycle, the set wins (mdu_busy stays 1).
- stall_cnt: increments when id_valid & ~nostall and saturates at 2^CW−1. stat_clr zeroes it, and stat_clr has priority over increment.
- At most one outstanding MDU op, so at most one sb_pend bit is set.

Decomposition:
- Shared package pipe_pkg holds:
  - forwarding-select constants FWD_RF=00, FWD_EXE=01, FWD_MEM=10, FWD_MLD=11;
  - default NREG/RW.
- One natural sub-module, pipe_fwd_sel: the combinational per-operand forwarding mux-select. It is instantiated twice, for rs and rt, and contains the FWD_EN gating.

Test Plan:
- Load-use: ewreg=em2reg=1, ern=5, id_rs=5, use_rs → nostall=0, stall_cnt 0→1. Next cycle, with the load in MEM (mrn=5, mm2reg=1, EX empty) → nostall=1, fwda=11.
- Priority: ern=mrn=7, ewreg=mwreg=1, em2reg=mm2reg=0, id_rt=7 → fwdb=01. Drop ewreg → fwdb=10. Repeat with FWD_EN=0 → fwdb=00 and nostall=0.
- Scoreboard RAW: issue id_long, id_rn=9 → sb_pend[9]=1, mdu_busy=1. Consumer rs=9 stalls until the cycle after mdu_done, mdu_rn=9, then issues. err_spurious stays 0.
- Structural/WAW: second id_long while busy → nostall=0. Present it with mdu_done in the same cycle → issue=1 and mdu_busy remains 1. WAW: id_wreg, id_rn=9, pending → stall.
- Reset mid-operation: sb_pend[9]=1, stall_cnt=3, assert resetn=0 asynchronously between edges → all state 0 immediately. Stalled consumer then issues.
- Error/saturation: mdu_done with mdu_rn=4 not pending → err_spurious=1 (sticky), cleared by stat_clr. With CW=2, 5 stall cycles → stall_cnt=3.
